flick_cond: RTL and testbench

Input conditioner for the bound flasher's `flick` request. It takes the raw, asynchronous flick push-button and synchronises and debounces it. It then produces a level `flick` that is stretched long enough for the flasher to sample it at its kickback points, which can be up to ~32 cycles apart. It also provides a one-cycle rise pulse and a saturating press counter for debug and status. The block sits directly upstream of the flasher's `flick` input, in the same clock domain.

---
 rtl/flick_cond.sv | 196 +++++++++++++++++++
 tb/tb_flick_cond.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flick_cond.sv
// flick_cond: conditions the raw flick push-button for the bound flasher.
//
// The raw button passes through a synchroniser and then a debounce FSM.
// The debounced level is stretched so that the flasher, which samples only
// at its kickback points, cannot miss a short press.
//
// Parameters
//   SYNC_STG : synchroniser flop stages (>= 2)
//   DB_CYC   : consecutive disagreeing samples needed to toggle btn_db (>= 2)
//   STR_CYC  : minimum flick high time after a debounced press (>= 1)
//   CNT_W    : press counter width
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   btn_in     : raw asynchronous button, may bounce
//   clr_cnt    : synchronous clear of press_cnt (wins over a coincident press)
//   btn_db     : debounced, synchronised button level (registered)
//   flick      : stretched request, btn_db | (stretch counter != 0)
//   flick_rise : one-cycle pulse on each debounced 0->1 transition (registered)
//   press_cnt  : saturating count of debounced presses
module flick_cond #(
  parameter int SYNC_STG = 2,
  parameter int DB_CYC   = 4,
  parameter int STR_CYC  = 32,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_in,
  input  logic             clr_cnt,
  output logic             btn_db,
  output logic             flick,
  output logic             flick_rise,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int DW = $clog2(DB_CYC);
  localparam int SW = $clog2(STR_CYC + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYC - 1);
  localparam logic [DW-1:0] DB_FIRST = DW'(1);
  localparam logic [SW-1:0] STR_LOAD = SW'(STR_CYC - 1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } db_state_t;

  logic [SYNC_STG-1:0] r_sync;
  logic                w_s_btn;

  db_state_t           r_state;
  db_state_t           w_state_nxt;
  logic [DW-1:0]       r_db_cnt;
  logic [DW-1:0]       w_db_cnt_nxt;
  logic                r_btn_db;
  logic                w_btn_db_nxt;
  logic                w_rise_nxt;
  logic                r_flick_rise;

  logic [SW-1:0]       r_str_cnt;
  logic [CNT_W-1:0]    r_press_cnt;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STG-2:0], btn_in};
    end
  end

  assign w_s_btn = r_sync[SYNC_STG-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE_LO;
      r_db_cnt     <= '0;
      r_btn_db     <= 1'b0;
      r_flick_rise <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_db_cnt     <= w_db_cnt_nxt;
      r_btn_db     <= w_btn_db_nxt;
      r_flick_rise <= w_rise_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: next state. The IDLE state already counts as the first
  // disagreeing sample, so CHK_* needs DB_CYC-1 more to toggle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_db_cnt_nxt = r_db_cnt;
    w_btn_db_nxt = r_btn_db;

    case (r_state)
      IDLE_LO: begin
        w_btn_db_nxt = 1'b0;
        if (w_s_btn) begin
          w_state_nxt  = CHK_HI;
          w_db_cnt_nxt = DB_FIRST;
        end
      end

      CHK_HI: begin
        if (!w_s_btn) begin
          w_state_nxt  = IDLE_LO;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt  = IDLE_HI;
          w_btn_db_nxt = 1'b1;
          w_db_cnt_nxt = '0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DB_FIRST;
        end
      end

      IDLE_HI: begin
        w_btn_db_nxt = 1'b1;
        if (!w_s_btn) begin
          w_state_nxt  = CHK_LO;
          w_db_cnt_nxt = DB_FIRST;
        end
      end

      CHK_LO: begin
        if (w_s_btn) begin
          w_state_nxt  = IDLE_HI;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt  = IDLE_LO;
          w_btn_db_nxt = 1'b0;
          w_db_cnt_nxt = '0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DB_FIRST;
        end
      end

      default: begin
        w_state_nxt  = IDLE_LO;
        w_btn_db_nxt = 1'b0;
        w_db_cnt_nxt = '0;
      end
    endcase
  end

  // Rise pulse registers on the same edge btn_db goes high.
  assign w_rise_nxt = w_btn_db_nxt & ~r_btn_db;

  // ---------------------------------------------------------------------------
  // Stretch counter. btn_db covers the first high cycle; loading STR_CYC-1
  // from the registered rise pulse covers the remaining cycles, giving an
  // exact STR_CYC-cycle minimum. A new rise reloads (retrigger).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_str_cnt <= '0;
    end else if (r_flick_rise) begin
      r_str_cnt <= STR_LOAD;
    end else if (r_str_cnt != '0) begin
      r_str_cnt <= r_str_cnt - SW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating press counter; clear wins over a coincident rise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_press_cnt <= '0;
    end else if (clr_cnt) begin
      r_press_cnt <= '0;
    end else if (r_flick_rise && (r_press_cnt != '1)) begin
      r_press_cnt <= r_press_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. flick is an OR of registered terms only.
  // ---------------------------------------------------------------------------
  assign btn_db     = r_btn_db;
  assign flick_rise = r_flick_rise;
  assign press_cnt  = r_press_cnt;
  assign flick      = r_btn_db | (r_str_cnt != '0);

endmodule

// File: tb/tb_flick_cond.sv
// Testbench for flick_cond: a fixed vector table, hand-written corner-case
// sequences and randomised stimulus, all checked against a behavioural model.
module tb_flick_cond;

  localparam int SYNC_STG = 2;
  localparam int DB_CYC   = 4;
  localparam int STR_CYC  = 32;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn_in = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             btn_db;
  logic             flick;
  logic             flick_rise;
  logic [CNT_W-1:0] press_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flick_cond #(
    .SYNC_STG (SYNC_STG),
    .DB_CYC   (DB_CYC),
    .STR_CYC  (STR_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .clr_cnt    (clr_cnt),
    .btn_db     (btn_db),
    .flick      (flick),
    .flick_rise (flick_rise),
    .press_cnt  (press_cnt)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: a delay line for synchronisation, a run-length of
  // disagreeing samples for debounce, and "cycles since last rise" for the
  // stretch.
  // ---------------------------------------------------------------------------
  int pipe_q[$];
  int m_db    = 0;
  int m_run   = 0;
  int m_rise  = 0;
  int m_since = 1000;
  int m_cnt   = 0;
  int m_flick = 0;

  task automatic model_step(input int rst, input int btn, input int clr);
    int s, old_db, old_rise;
    if (rst == 0) begin
      pipe_q.delete();
      for (int i = 0; i < SYNC_STG; i++) pipe_q.push_back(0);
      m_db = 0; m_run = 0; m_rise = 0; m_since = 1000; m_cnt = 0;
    end else begin
      s = pipe_q.pop_front();
      pipe_q.push_back(btn);
      old_db   = m_db;
      old_rise = m_rise;
      if (s != m_db) begin
        m_run++;
        if (m_run == DB_CYC) begin
          m_db  = 1 - m_db;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_rise = (m_db == 1 && old_db == 0) ? 1 : 0;
      if (m_rise == 1) m_since = 0;
      else if (m_since < 1000) m_since++;
      if (clr != 0) m_cnt = 0;
      else if (old_rise == 1 && m_cnt < CNT_MAX) m_cnt++;
    end
    m_flick = (m_db == 1 || m_since < STR_CYC) ? 1 : 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance, update model, compare away from edge.
  task automatic tick(input int rst, input int btn, input int clr);
    rst_n   = (rst != 0);
    btn_in  = (btn != 0);
    clr_cnt = (clr != 0);
    @(posedge clk);
    model_step(rst, btn, clr);
    @(negedge clk);
    check("model btn_db", int'(btn_db), m_db);
    check("model flick", int'(flick), m_flick);
    check("model flick_rise", int'(flick_rise), m_rise);
    check("model press_cnt", int'(press_cnt), m_cnt);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: one row per edge, expected outputs after that edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    int rst; int btn; int clr;
    int e_db; int e_fl; int e_rise; int e_cnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int r1, r2, last_hi, hi_cnt, rises, any_hi, db_hi, seen, lvl, len;

    // reset held with button high, then release with button still high
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 1, 1, 1, 0};
    tbl[9]  = '{1, 1, 0, 1, 1, 0, 1};
    // release: btn_db falls 5 edges later, flick still stretched
    tbl[10] = '{1, 0, 0, 1, 1, 0, 1};
    tbl[11] = '{1, 0, 0, 1, 1, 0, 1};
    tbl[12] = '{1, 0, 0, 1, 1, 0, 1};
    tbl[13] = '{1, 0, 0, 1, 1, 0, 1};
    tbl[14] = '{1, 0, 0, 1, 1, 0, 1};
    tbl[15] = '{1, 0, 0, 0, 1, 0, 1};
    tbl[16] = '{1, 0, 1, 0, 1, 0, 0};
    tbl[17] = '{1, 0, 0, 0, 1, 0, 0};

    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].rst, tbl[i].btn, tbl[i].clr);
      check($sformatf("tbl[%0d] btn_db", i), int'(btn_db), tbl[i].e_db);
      check($sformatf("tbl[%0d] flick", i), int'(flick), tbl[i].e_fl);
      check($sformatf("tbl[%0d] flick_rise", i), int'(flick_rise), tbl[i].e_rise);
      check($sformatf("tbl[%0d] press_cnt", i), int'(press_cnt), tbl[i].e_cnt);
    end

    // --- Bounce: never debounces ---
    do_reset();
    any_hi = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1, (i % 2 == 0) ? 1 : 0, 0);
      if (btn_db || flick || flick_rise) any_hi = 1;
    end
    for (int i = 0; i < 23; i++) begin
      tick(1, (i < 3) ? 1 : 0, 0);
      if (btn_db || flick || flick_rise) any_hi = 1;
    end
    check("bounce any output high", any_hi, 0);
    check("bounce press_cnt", int'(press_cnt), 0);

    // --- Short press: flick high exactly STR_CYC cycles ---
    do_reset();
    hi_cnt = 0; db_hi = 0; rises = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1, (i < 6) ? 1 : 0, 0);
      if (flick) hi_cnt++;
      if (btn_db) db_hi++;
      if (flick_rise) rises++;
    end
    check("short press btn_db high cycles", db_hi, 6);
    check("short press flick high cycles", hi_cnt, STR_CYC);
    check("short press rise count", rises, 1);

    // --- Retrigger: second rise 10 cycles after first ---
    do_reset();
    r1 = -1; r2 = -1; last_hi = -1; rises = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1, ((i < 6) || (i >= 10 && i < 16)) ? 1 : 0, 0);
      if (flick_rise) begin
        rises++;
        if (r1 < 0) r1 = i; else r2 = i;
      end
      if (flick) last_hi = i;
    end
    check("retrigger rise count", rises, 2);
    check("retrigger rise spacing", r2 - r1, 10);
    check("retrigger flick tail", last_hi - r2 + 1, STR_CYC);
    check("retrigger press_cnt", int'(press_cnt), 2);

    // --- Saturation then clear coincident with flick_rise ---
    do_reset();
    for (int p = 0; p < 260; p++) begin
      for (int i = 0; i < 16; i++) tick(1, (i < 6) ? 1 : 0, 0);
    end
    check("saturated press_cnt", int'(press_cnt), CNT_MAX);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick(1, 1, 0);
      if (flick_rise) seen = 1;
    end
    check("clr: flick_rise seen in budget", seen, 1);
    tick(1, 1, 1);
    check("clr over rise press_cnt", int'(press_cnt), 0);
    for (int i = 0; i < 12; i++) tick(1, 0, 0);

    // --- Reset mid-stretch ---
    do_reset();
    r1 = -1;
    for (int i = 0; i < 40 && r1 < 0; i++) begin
      tick(1, (i < 6) ? 1 : 0, 0);
      if (flick_rise) r1 = i;
    end
    check("mid-stretch rise seen in budget", (r1 >= 0) ? 1 : 0, 1);
    for (int i = 0; i < 14; i++) tick(1, 0, 0);
    check("mid-stretch flick before reset", int'(flick), 1);
    tick(0, 0, 0);
    check("mid-stretch flick after reset", int'(flick), 0);
    check("mid-stretch press_cnt after reset", int'(press_cnt), 0);
    any_hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1, 0, 0);
      if (flick) any_hi = 1;
    end
    check("mid-stretch no flick afterwards", any_hi, 0);

    // --- Randomised stimulus against the model ---
    do_reset();
    for (int seg = 0; seg < 300; seg++) begin
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        tick(($urandom_range(0, 199) == 0) ? 0 : 1, lvl,
             ($urandom_range(0, 29) == 0) ? 1 : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
